// File: rtl/rvm_mem_responder.sv
// ---------------------------------------------------------------------------
// rvm_mem_responder
//   Memory-side responder for the core's req/gnt memory interface. Holds a
//   word-addressed RAM of DEPTH 32-bit words mapped at BASE_ADDR. It takes
//   one request at a time and answers after LATENCY wait cycles with a
//   one-cycle gnt strobe, read data and an error flag.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   mem_req    request valid, held with stable fields until mem_gnt
//   mem_wen    1 = write, 0 = read
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_ben    byte-lane enables, bit i selects wdata[8i+7:8i]
//   mem_gnt    one-cycle response strobe (registered)
//   mem_rdata  read data, zero whenever mem_gnt is low
//   mem_error  bus error, zero whenever mem_gnt is low
// ---------------------------------------------------------------------------
module rvm_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_ben,
    output logic        mem_gnt,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int          IDX_W  = $clog2(DEPTH);
    localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
    localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_check
        $error("rvm_mem_responder: LATENCY must be in 0..15");
    end

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_ben;

    logic              cur_wen;
    logic [31:0]       cur_addr;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic              enter_resp;

    logic [31:0] ram [DEPTH];

    function automatic logic addr_err(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (off >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // With LATENCY = 0 the response is prepared on the capture edge itself,
    // so the live request fields are used in IDLE and the latched ones after.
    always_comb begin
        cur_wen  = lat_wen;
        cur_addr = lat_addr;
        if (state == S_IDLE) begin
            cur_wen  = mem_wen;
            cur_addr = mem_addr;
        end
        cur_err = addr_err(cur_addr);
        // An erroring address never indexes the RAM, so no wrapped access.
        cur_idx = cur_err ? '0 : addr_idx(cur_addr);
        enter_resp = ((state == S_IDLE) && mem_req && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));
    end

    // Request capture: fields are sampled only in IDLE and never re-sampled.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && mem_req) begin
            lat_wen   <= mem_wen;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_ben   <= mem_ben;
        end
    end

    // Control FSM and registered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            mem_gnt   <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (enter_resp) begin
                mem_gnt   <= 1'b1;
                mem_error <= cur_err;
                mem_rdata <= (cur_err || cur_wen) ? 32'd0 : ram[cur_idx];
            end else begin
                mem_gnt   <= 1'b0;
                mem_error <= 1'b0;
                mem_rdata <= 32'd0;
            end
        end
    end

    // Write commit on the edge closing RESP; a reset before then (WAIT)
    // forces state to IDLE so the write is dropped.
    always_ff @(posedge clk) begin
        if (state == S_RESP && lat_wen && !addr_err(lat_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_ben[i]) begin
                    ram[addr_idx(lat_addr)][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rvm_mem_responder.sv
module tb_rvm_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with LATENCY = 2
    logic        rstn2, req2, wen2, gnt2, err2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  ben2;
    // Instance with LATENCY = 0
    logic        rstn0, req0, wen0, gnt0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  ben0;

    rvm_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u2 (
        .clk(clk), .resetn(rstn2), .mem_req(req2), .mem_wen(wen2),
        .mem_addr(addr2), .mem_wdata(wdata2), .mem_ben(ben2),
        .mem_gnt(gnt2), .mem_rdata(rdata2), .mem_error(err2)
    );

    rvm_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u0 (
        .clk(clk), .resetn(rstn0), .mem_req(req0), .mem_wen(wen0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_ben(ben0),
        .mem_gnt(gnt0), .mem_rdata(rdata0), .mem_error(err0)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] ben);
        if (sel == 0) begin
            req0 = req; wen0 = wen; addr0 = addr; wdata0 = wdata; ben0 = ben;
        end else begin
            req2 = req; wen2 = wen; addr2 = addr; wdata2 = wdata; ben2 = ben;
        end
    endtask

    task automatic get(input int sel, output logic g, output logic [31:0] rd, output logic e);
        if (sel == 0) begin
            g = gnt0; rd = rdata0; e = err0;
        end else begin
            g = gnt2; rd = rdata2; e = err2;
        end
    endtask

    // One transaction: request is dropped and its fields scrambled right
    // after capture, so the response must come from the captured values.
    task automatic txn(input int sel, input string name, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] ben, input logic [31:0] exp_rd,
                       input logic exp_err);
        int k;
        int lat;
        logic g, e, quiet;
        logic [31:0] rd;
        lat = (sel == 0) ? 0 : 2;
        @(negedge clk);
        drive(sel, 1'b1, wen, addr, wdata, ben);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, ~wen, ~addr, ~wdata, ~ben);
        k = 1;
        quiet = 1'b1;
        get(sel, g, rd, e);
        while (!g && k < 20) begin
            if (rd !== 32'd0 || e !== 1'b0) quiet = 1'b0;
            @(posedge clk);
            #1;
            k++;
            get(sel, g, rd, e);
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no gnt within %0d cycles", name, k);
            return;
        end
        chk({name, " latency"}, 32'(k), 32'(lat + 1));
        chk({name, " rdata"}, rd, exp_rd);
        chk({name, " error"}, {31'd0, e}, {31'd0, exp_err});
        chk({name, " quiet-before-gnt"}, {31'd0, quiet}, 32'd1);
        @(posedge clk);
        #1;
        get(sel, g, rd, e);
        chk({name, " gnt-drop"}, {31'd0, g, rd[0] | e}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h10,       32'h11223344, 4'b0101, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDE22BE44, 1'b0};
        vt[4]  = '{1'b0, 32'h13,       32'h0,        4'h0,    32'h0,        1'b1};
        vt[5]  = '{1'b1, 32'h0,        32'hA5A5A5A5, 4'hF,    32'h0,        1'b0};
        vt[6]  = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
        vt[7]  = '{1'b0, 32'h0,        32'h0,        4'h0,    32'hA5A5A5A5, 1'b0};
        vt[8]  = '{1'b1, 32'h4,        32'h0BADCAFE, 4'hF,    32'h0,        1'b0};
        vt[9]  = '{1'b1, 32'h4,        32'h12345678, 4'h0,    32'h0,        1'b0};
        vt[10] = '{1'b0, 32'h4,        32'h0,        4'h0,    32'h0BADCAFE, 1'b0};
        vt[11] = '{1'b1, 32'h20,       32'h01020304, 4'hF,    32'h0,        1'b0};
        vt[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0,    32'h0,        1'b1};
        vt[13] = '{1'b1, 32'hFFC,      32'h55AA55AA, 4'hF,    32'h0,        1'b0};
        vt[14] = '{1'b0, 32'hFFC,      32'h0,        4'h0,    32'h55AA55AA, 1'b0};

        // Reset then idle
        rstn2 = 1'b0; rstn0 = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset u2", {gnt2, err2, rdata2[29:0]}, 32'd0);
        chk("reset u0", {gnt0, err0, rdata0[29:0]}, 32'd0);
        @(negedge clk);
        rstn2 = 1'b1; rstn0 = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (gnt2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 32'd0) ok = 1'b0;
            if (gnt0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'd0) ok = 1'b0;
        end
        chk("idle quiet", {31'd0, ok}, 32'd1);

        // Table-driven transactions, LATENCY = 2
        for (int i = 0; i < 15; i++) begin
            txn(2, $sformatf("vec%0d", i), vt[i].wen, vt[i].addr, vt[i].wdata,
                vt[i].ben, vt[i].exp_rd, vt[i].exp_err);
        end

        // Reset during WAIT of a write: no gnt, RAM keeps old value
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rstn2 = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (gnt2 !== 1'b0) ok = 1'b0;
        end
        @(negedge clk);
        rstn2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (gnt2 !== 1'b0) ok = 1'b0;
        end
        chk("midreset no-gnt", {31'd0, ok}, 32'd1);
        txn(2, "midreset readback", 1'b0, 32'h20, 32'd0, 4'd0, 32'h01020304, 1'b0);

        // LATENCY = 0: preload, then back-to-back reads with req held high
        for (int i = 0; i < 4; i++) begin
            txn(0, $sformatf("l0 wr%0d", i), 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i),
                4'hF, 32'h0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 1'b0, 32'(i * 4), 32'd0, 4'd0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d gnt", i), {31'd0, gnt0}, 32'd1);
            chk($sformatf("b2b%0d rdata", i), rdata0, 32'hC0DE0000 + 32'(i));
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d gap", i), {31'd0, gnt0}, 32'd0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvm_mem_responder.md
Name: rvm_mem_responder

Overview:
- Memory-side responder for the req/gnt memory interface driven by the core's control FSM (rvm_control) for instruction fetch and load/store.
- Holds a word-addressed RAM of DEPTH 32-bit words at BASE_ADDR.
- Accepts one request at a time and answers after a fixed, parameterised latency with read data and an error flag.
- Used as the simulation/FPGA memory model behind the multi-cycle core.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- LATENCY, 2, wait cycles between request capture and response; range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- mem_req  input  1  request valid; held high with stable fields until mem_gnt.
- mem_wen  input  1  1 = write, 0 = read.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_ben  input  4  byte-lane enables; bit i selects wdata[8i+7:8i].
- mem_gnt  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data; valid while mem_gnt is high.
- mem_error  output  1  bus error; valid while mem_gnt is high.

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk.
  - Under reset: state = IDLE, mem_gnt = 0, mem_rdata = 0, mem_error = 0, wait counter = 0.
  - RAM contents are not reset.
- States:
  - IDLE: on a clk edge with mem_req = 1, latch wen/addr/wdata/ben. Go to WAIT with counter = LATENCY-1 if LATENCY > 0; go to RESP if LATENCY = 0.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: mem_gnt = 1 for exactly this cycle, with mem_rdata and mem_error driven. Next state is IDLE.
- Latency:
  - mem_gnt rises LATENCY+1 cycles after the edge that sampled mem_req.
  - LATENCY = 0 gives gnt on the cycle after capture.
- Outputs are registered. mem_gnt, mem_rdata and mem_error change only on clk edges.
  - mem_rdata = 0 and mem_error = 0 whenever mem_gnt = 0.
- Back-to-back requests:
  - mem_req is ignored in WAIT and RESP.
  - The initiator drops mem_req in the cycle after gnt, or presents the next request then.
  - A request still high in the first IDLE cycle after RESP is captured as a new request.
  - Minimum request period: LATENCY+2 cycles.
- Decode, on latched values:
  - offset = addr - BASE_ADDR.
  - Error if addr[1:0] != 0, or addr < BASE_ADDR, or offset >= DEPTH*4.
  - Word index = offset[log2(DEPTH)+1:2].
- Read: mem_rdata = RAM[index] as it stood at the RESP cycle.
- Write:
  - Each enabled byte lane is written on the RESP-cycle edge; disabled lanes are unchanged.
  - mem_rdata = 0 in the response.
  - mem_ben = 0 is a legal no-op write and returns gnt with no error.
- Error response:
  - mem_error = 1 and mem_rdata = 0.
  - No RAM write occurs, and no out-of-range or wrapped index is accessed.
  - Latency is unchanged.
- Protocol violation: if mem_req or its fields change before gnt, the latched request completes unchanged. Fields are never re-sampled mid-transaction.
- Reset mid-operation (resetn low in WAIT or RESP):
  - The transaction is abandoned and no gnt is issued.
  - A write not yet committed (still in WAIT) leaves RAM unchanged.
- Counter width is 4 bits. LATENCY > 15 is unsupported and is flagged by a simulation-time check.

Test Plan:
1. Reset then idle, LATENCY=2: hold resetn low 3 cycles, mem_req=0 for 10 cycles -> mem_gnt, mem_rdata and mem_error stay 0 throughout.
2. Write then read, LATENCY=2:
   - Write addr 0x10, wdata 0xDEADBEEF, ben 4'hF -> gnt exactly 3 cycles after the capture edge, error 0.
   - Then read 0x10 -> gnt after 3 cycles with rdata 0xDEADBEEF.
3. Byte lanes: after step 2, write 0x10 with wdata 0x11223344, ben 4'b0101 -> subsequent read returns 0xDE22BE44.
4. Errors:
   - Read 0x13 (misaligned) -> gnt with error 1, rdata 0.
   - Write to BASE_ADDR+DEPTH*4 (0x1000 at defaults) -> error 1, and a read of 0x0 is unchanged.
5. LATENCY=0 back-to-back: keep req high across 4 reads of 0x0, 0x4, 0x8, 0xC -> a gnt every 2 cycles with correct data each time.
6. Reset mid-write: write 0x20 with data 0xCAFEF00D, assert resetn low in the WAIT cycle -> no gnt, and a later read of 0x20 returns its prior value.
